// File: rtl/router_reg_nch_if.sv
// Bus between the router FSM/input port and the router datapath register block.
// The slave side is the register block; the master side drives the byte stream
// and FSM strobes and observes the FIFO write data and packet status.
interface router_reg_nch_if #(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 8
);
  logic                 pkt_valid;
  logic [DATA_W-1:0]    data_in;
  logic                 fifo_full;
  logic                 detect_add;
  logic                 lfd_state;
  logic                 ld_state;
  logic                 laf_state;
  logic                 full_state;
  logic                 rst_int_reg;
  logic [DATA_W-1:0]    dout;
  logic                 parity_done;
  logic                 low_pkt_valid;
  logic                 err;
  logic                 len_err;
  logic                 pkt_done;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_pkt_valid, err, len_err, pkt_done, err_cnt
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_pkt_valid, err, len_err, pkt_done, err_cnt
  );
endinterface

// File: rtl/router_reg_nch.sv
// Datapath register block of a 1xN packet router: captures the header,
// forwards header/payload/parity bytes to the channel FIFO write bus, holds
// the byte refused by a full FIFO, and checks parity and payload length once
// per packet with a saturating error counter.
module router_reg_nch #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 2,
  parameter int NUM_CH    = 3,
  parameter int CHECK_LEN = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic           clock,
  input  logic           resetn,
  router_reg_nch_if.slave bus
);
  localparam int LEN_W = DATA_W - ADDR_W;

  logic [DATA_W-1:0]    header_reg;
  logic [DATA_W-1:0]    hold_reg;
  logic [DATA_W-1:0]    int_par;
  logic [DATA_W-1:0]    pkt_par;
  logic [LEN_W:0]       pay_cnt;
  logic [DATA_W-1:0]    dout_reg;
  logic                 parity_done_reg;
  logic                 low_pkt_valid_reg;
  logic                 err_reg;
  logic                 len_err_reg;
  logic                 pkt_done_reg;
  logic                 chk_armed;
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  logic [31:0] dest_ext;
  logic        header_ok;
  logic        payload_take;
  logic        check_fire;
  logic        par_mismatch;
  logic        len_mismatch;

  assign dest_ext     = 32'(bus.data_in[ADDR_W-1:0]);
  assign header_ok    = bus.detect_add && bus.pkt_valid && (dest_ext < 32'(NUM_CH));
  assign payload_take = bus.ld_state && bus.pkt_valid && !bus.full_state;
  assign check_fire   = parity_done_reg && !chk_armed;
  assign par_mismatch = (int_par != pkt_par);
  assign len_mismatch = (CHECK_LEN != 0) &&
                        (pay_cnt != {1'b0, header_reg[DATA_W-1:ADDR_W]});

  // Capture the header only when its destination names an existing channel.
  always_ff @(posedge clock) begin
    if (!resetn)        header_reg <= '0;
    else if (header_ok) header_reg <= bus.data_in;
  end

  // Running parity over header and accepted payload bytes.
  always_ff @(posedge clock) begin
    if (!resetn)             int_par <= '0;
    else if (bus.detect_add) int_par <= '0;
    else if (bus.lfd_state)  int_par <= int_par ^ header_reg;
    else if (payload_take)   int_par <= int_par ^ bus.data_in;
  end

  // Payload byte counter, saturating so an overlong packet still reports a length error.
  always_ff @(posedge clock) begin
    if (!resetn)                           pay_cnt <= '0;
    else if (bus.detect_add)               pay_cnt <= '0;
    else if (payload_take && pay_cnt != '1) pay_cnt <= pay_cnt + 1'b1;
  end

  // Parity byte as sent by the source, and the byte a full FIFO refused.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pkt_par  <= '0;
      hold_reg <= '0;
    end else begin
      if (bus.detect_add)                   pkt_par <= '0;
      else if (bus.ld_state && !bus.pkt_valid) pkt_par <= bus.data_in;
      if (bus.ld_state && bus.fifo_full)    hold_reg <= bus.data_in;
    end
  end

  // FIFO write data: header on lfd, live byte when the FIFO accepts, held byte after a stall.
  always_ff @(posedge clock) begin
    if (!resetn)                                 dout_reg <= '0;
    else if (header_ok)                          dout_reg <= dout_reg;
    else if (bus.lfd_state)                      dout_reg <= header_reg;
    else if (bus.ld_state && !bus.fifo_full)     dout_reg <= bus.data_in;
    else if (bus.ld_state && bus.fifo_full)      dout_reg <= dout_reg;
    else if (bus.laf_state)                      dout_reg <= hold_reg;
  end

  // Sticky flags marking that the parity byte was seen and that it reached the FIFO.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      low_pkt_valid_reg <= 1'b0;
      parity_done_reg   <= 1'b0;
    end else begin
      if (bus.rst_int_reg)                     low_pkt_valid_reg <= 1'b0;
      else if (bus.ld_state && !bus.pkt_valid) low_pkt_valid_reg <= 1'b1;

      if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
          (bus.laf_state && low_pkt_valid_reg && !parity_done_reg))
        parity_done_reg <= 1'b1;
      else if (bus.detect_add)
        parity_done_reg <= 1'b0;
    end
  end

  // One-shot packet check; a coincident detect_add lets the check finish and re-arms for the next packet.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      err_reg      <= 1'b0;
      len_err_reg  <= 1'b0;
      pkt_done_reg <= 1'b0;
      chk_armed    <= 1'b0;
      err_cnt_reg  <= '0;
    end else begin
      pkt_done_reg <= check_fire;
      if (bus.detect_add)   chk_armed <= 1'b0;
      else if (check_fire)  chk_armed <= 1'b1;
      if (check_fire) begin
        err_reg     <= par_mismatch;
        len_err_reg <= len_mismatch;
        if ((par_mismatch || len_mismatch) && err_cnt_reg != '1)
          err_cnt_reg <= err_cnt_reg + 1'b1;
      end else if (bus.detect_add) begin
        err_reg     <= 1'b0;
        len_err_reg <= 1'b0;
      end
    end
  end

  assign bus.dout          = dout_reg;
  assign bus.parity_done   = parity_done_reg;
  assign bus.low_pkt_valid = low_pkt_valid_reg;
  assign bus.err           = err_reg;
  assign bus.len_err       = len_err_reg;
  assign bus.pkt_done      = pkt_done_reg;
  assign bus.err_cnt       = err_cnt_reg;
endmodule
